// File: rtl/pe_maxpool2x2.sv
// -----------------------------------------------------------------------------
// pe_maxpool2x2
//   2x2 stride-2 max-pooling stage that sits directly after the PE array.
//   It consumes the PE raster stream one pixel at a time per channel. For each
//   2x2 window it emits one pooled sample per channel. Every channel has its own
//   column/row tracking, so channels may be enabled on unrelated cycles. The
//   output width equals the input width, so this stage can feed the next PE row
//   unchanged.
//
// Parameters
//   LINES   pixels per input line (even, >= 2)
//   CL_IN   number of channels
//   N       sample width
//   SIGNED  1: compare samples as two's complement, 0: compare as unsigned
//
// Ports
//   clk     in   1          rising-edge clock
//   rst     in   1          asynchronous active-low reset
//   clr     in   1          synchronous frame restart (wins over en_in)
//   d_in    in   CL_IN*N    channel i sample in d_in[i*N +: N]
//   en_in   in   CL_IN      en_in[i]: channel i sample valid this cycle
//   d_out   out  CL_IN*N    pooled sample, channel i in d_out[i*N +: N]
//   en_out  out  CL_IN      one-cycle pulse: d_out channel i is new
// -----------------------------------------------------------------------------
module pe_maxpool2x2 #(
  parameter int LINES  = 16,
  parameter int CL_IN  = 4,
  parameter int N      = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [CL_IN*N-1:0] d_in,
  input  logic [CL_IN-1:0]   en_in,
  output logic [CL_IN*N-1:0] d_out,
  output logic [CL_IN-1:0]   en_out
);

  localparam int HALF = LINES / 2;
  localparam int CW   = (LINES > 2) ? $clog2(LINES) : 1;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINES - 1);

  // Larger of two samples in the configured number format. On a tie either
  // operand is fine because they are equal.
  function automatic logic [N-1:0] max2(input logic [N-1:0] a, input logic [N-1:0] b);
    logic a_gt;
    if (SIGNED) a_gt = ($signed(a) > $signed(b));
    else        a_gt = (a > b);
    return a_gt ? a : b;
  endfunction

  for (genvar gi = 0; gi < CL_IN; gi++) begin : g_ch
    logic [N-1:0]  x;
    logic [CW-1:0] col_q, col_d;
    logic          row_q, row_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          en_q, en_d;
    logic [N-1:0]  lb [HALF];
    logic [N-1:0]  lb_rd_q;
    logic [AW-1:0] lb_addr;
    logic          lb_we;
    logic [N-1:0]  pair_max;

    assign x        = d_in[gi*N +: N];
    assign pair_max = max2(hold_q, x);

    // Both pixels of a horizontal pair share one line-buffer slot. The slot is
    // read every cycle using the current column. The cycle that accepts the
    // even pixel therefore loads the slot the odd pixel needs. Idle cycles
    // between the two pixels re-read the same slot. This lets the line buffer
    // use a registered read without adding latency.
    assign lb_addr = AW'(col_q >> 1);
    assign lb_we   = en_in[gi] & ~clr & col_q[0] & ~row_q;

    always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      hold_d = hold_q;
      dout_d = dout_q;
      en_d   = 1'b0;
      if (clr) begin
        // Frame restart: the sample presented with clr is dropped.
        col_d  = '0;
        row_d  = 1'b0;
        hold_d = '0;
      end else if (en_in[gi]) begin
        if (!col_q[0]) begin
          hold_d = x;
        end else if (row_q) begin
          dout_d = max2(pair_max, lb_rd_q);
          en_d   = 1'b1;
        end
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = ~row_q;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        col_q  <= '0;
        row_q  <= 1'b0;
        hold_q <= '0;
        dout_q <= '0;
        en_q   <= 1'b0;
      end else begin
        col_q  <= col_d;
        row_q  <= row_d;
        hold_q <= hold_d;
        dout_q <= dout_d;
        en_q   <= en_d;
      end
    end

    // The line buffer has no reset. Row 0 writes every slot before row 1 reads it.
    always_ff @(posedge clk) begin
      if (lb_we) lb[lb_addr] <= pair_max;
      lb_rd_q <= lb[lb_addr];
    end

    assign d_out[gi*N +: N] = dout_q;
    assign en_out[gi]       = en_q;
  end

endmodule
